// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - bus bundle between two fetch/load masters, the arbiter and the RAM
interface imem_arbiter_if #(
    parameter int ADDR_W = 16
) ();
    logic              m0_req_i;
    logic [31:0]       m0_addr_i;
    logic              m0_gnt_o;
    logic              m0_rvalid_o;
    logic [31:0]       m0_rdata_o;

    logic              m1_req_i;
    logic              m1_we_i;
    logic [31:0]       m1_addr_i;
    logic [31:0]       m1_wdata_i;
    logic              m1_gnt_o;
    logic              m1_rvalid_o;
    logic [31:0]       m1_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    modport slave (
        input  m0_req_i, m0_addr_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_addr_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - round-robin core/loader arbiter for one instruction RAM port
// Optional boot hold (m0 blocked until boot_done_i) enabled by macro IMEM_ARB_BOOT_HOLD_EN.
module imem_arbiter #(
    parameter int ADDR_W = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
`ifdef IMEM_ARB_BOOT_HOLD_EN
    input  logic boot_done_i,
`endif
    imem_arbiter_if.slave bus
);

    logic        run_mode;
    logic        prio_m1;
    logic        gnt0;
    logic        gnt1;
    logic        in_range0;
    logic        in_range1;
    logic        sel_in_range;
    logic [31:0] sel_addr;
    logic        rsp_v0;
    logic        rsp_v1;
    logic        rsp_rd;

`ifdef IMEM_ARB_BOOT_HOLD_EN
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } boot_state_e;

    boot_state_e state_q;
    boot_state_e state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave BOOT only once no loader response is still in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    if (boot_done_i && !rsp_v1) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    assign run_mode = (state_q == RUN);
`else
    assign run_mode = 1'b1;
`endif

    assign in_range0 = (bus.m0_addr_i[31:ADDR_W] == '0);
    assign in_range1 = (bus.m1_addr_i[31:ADDR_W] == '0);

    // prio_m1 set means m0 won last, so m1 wins the next contested cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_ni) begin
            if (run_mode && bus.m0_req_i && !(bus.m1_req_i && prio_m1)) begin
                gnt0 = 1'b1;
            end else if (bus.m1_req_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign sel_addr     = gnt1 ? bus.m1_addr_i : bus.m0_addr_i;
    assign sel_in_range = gnt1 ? in_range1 : in_range0;

    assign bus.m0_gnt_o    = gnt0;
    assign bus.m1_gnt_o    = gnt1;
    assign bus.mem_req_o   = (gnt0 || gnt1) && sel_in_range;
    assign bus.mem_we_o    = gnt1 && in_range1 && bus.m1_we_i;
    assign bus.mem_addr_o  = bus.mem_req_o ? sel_addr[ADDR_W-1:0] : '0;
    assign bus.mem_wdata_o = (gnt1 && in_range1) ? bus.m1_wdata_i : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_m1 <= 1'b0;
            rsp_v0  <= 1'b0;
            rsp_v1  <= 1'b0;
            rsp_rd  <= 1'b0;
        end else begin
            rsp_v0 <= gnt0;
            rsp_v1 <= gnt1;
            rsp_rd <= bus.mem_req_o && !bus.mem_we_o;
            if (gnt0) begin
                prio_m1 <= 1'b1;
            end else if (gnt1) begin
                prio_m1 <= 1'b0;
            end
        end
    end

    // Writes and out-of-range accesses answer with zero data.
    assign bus.m0_rvalid_o = rsp_v0;
    assign bus.m1_rvalid_o = rsp_v1;
    assign bus.m0_rdata_o  = (rsp_v0 && rsp_rd) ? bus.mem_rdata_i : 32'h0;
    assign bus.m1_rdata_o  = (rsp_v1 && rsp_rd) ? bus.mem_rdata_i : 32'h0;

endmodule
